sensor_scan_ctrl: RTL and testbench

Round-robin scheduler that shares one pwm_measure instance between N_SENSORS PWM-echo distance sensors. For each sensor in turn it:
- clears the measurer;
- fires that sensor's trigger;
- routes the sensor's synchronised PWM line to the measurer;
- detects the end of the pulse, or a timeout;
- latches the result into a per-sensor distance register.

It sits between the sensor pins and the single pwm_measure block and feeds downstream consumers.

---
 rtl/sensor_scan_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_sensor_scan_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sensor_scan_ctrl.sv
// Round-robin scheduler that shares one pwm_measure instance between several
// PWM-echo distance sensors: clear, trigger, route echo, detect end or timeout,
// and latch the result per sensor.
module sensor_scan_ctrl #(
    parameter int unsigned    N_SENSORS      = 4,
    parameter int unsigned    DW             = 16,
    parameter int unsigned    TRIG_CYCLES    = 1000,
    parameter int unsigned    TIMEOUT_CYCLES = 3000000,
    parameter int unsigned    SETTLE_CYCLES  = 2,
    parameter int unsigned    GAP_CYCLES     = 100,
    parameter logic [DW-1:0]  TIMEOUT_VALUE  = '1,
    localparam int unsigned   IW = (N_SENSORS > 1) ? $clog2(N_SENSORS) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [N_SENSORS-1:0]    pwm_in,
    output logic [N_SENSORS-1:0]    trig,
    output logic                    pwm_out,
    output logic                    meas_reset,
    input  logic [DW-1:0]           meas_distance,
    output logic [N_SENSORS*DW-1:0] dist_out,
    output logic                    dist_valid,
    output logic [IW-1:0]           dist_idx,
    output logic [N_SENSORS-1:0]    timeout_flags,
    output logic                    scan_done
);

    // One shared phase counter, wide enough for the longest phase.
    localparam int unsigned MAX_A   = (TIMEOUT_CYCLES > TRIG_CYCLES) ? TIMEOUT_CYCLES
                                                                     : TRIG_CYCLES;
    localparam int unsigned MAX_B   = (GAP_CYCLES > SETTLE_CYCLES) ? GAP_CYCLES : SETTLE_CYCLES;
    localparam int unsigned MAX_C   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned MAX_CNT = (MAX_C > 2) ? MAX_C : 2;
    localparam int unsigned CW      = (MAX_CNT > 2) ? $clog2(MAX_CNT) : 1;

    typedef enum logic [3:0] {
        StIdle, StClear, StTrig, StWaitHigh, StWaitLow, StSettle, StStore, StStoreTo, StGap
    } state_e;

    state_e                 state_q, state_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [N_SENSORS-1:0]   pwm_meta_q, pwm_sync_q;
    logic                   sel_dly_q;
    logic [N_SENSORS*DW-1:0] dist_q;
    logic [N_SENSORS-1:0]   to_flags_q;
    logic                   scan_done_q, scan_done_d;

    logic sel, rise, fall, timed_out, route_pwm;

    assign sel       = pwm_sync_q[idx_q];
    assign rise      = sel & ~sel_dly_q;
    assign fall      = ~sel & sel_dly_q;
    assign timed_out = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    // Synchronisers, selected-line delay and FSM state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_meta_q  <= '0;
            pwm_sync_q  <= '0;
            sel_dly_q   <= 1'b0;
            state_q     <= StIdle;
            idx_q       <= '0;
            cnt_q       <= '0;
            scan_done_q <= 1'b0;
        end else begin
            pwm_meta_q  <= pwm_in;
            pwm_sync_q  <= pwm_meta_q;
            sel_dly_q   <= sel;
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            scan_done_q <= scan_done_d;
        end
    end

    // Result registers: written only in the single-cycle store states.
    always_ff @(posedge clk) begin
        if (reset) begin
            dist_q     <= '0;
            to_flags_q <= '0;
        end else if (state_q == StStore) begin
            dist_q[idx_q*DW +: DW] <= meas_distance;
            to_flags_q[idx_q]      <= 1'b0;
        end else if (state_q == StStoreTo) begin
            dist_q[idx_q*DW +: DW] <= TIMEOUT_VALUE;
            to_flags_q[idx_q]      <= 1'b1;
        end
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        scan_done_d = 1'b0;
        trig        = '0;
        meas_reset  = 1'b0;
        dist_valid  = 1'b0;
        route_pwm   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (enable) begin
                    idx_d   = '0;
                    cnt_d   = '0;
                    state_d = StClear;
                end
            end
            StClear: begin
                meas_reset = 1'b1;
                if (cnt_q == CW'(1)) begin
                    cnt_d   = '0;
                    state_d = StTrig;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StTrig: begin
                trig = N_SENSORS'(1) << idx_q;
                if (cnt_q == CW'(TRIG_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = StWaitHigh;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StWaitHigh: begin
                route_pwm = 1'b1;
                // Timeout wins so the counter can never step past its limit.
                if (timed_out) begin
                    state_d = StStoreTo;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (rise) state_d = StWaitLow;
                end
            end
            StWaitLow: begin
                route_pwm = 1'b1;
                if (timed_out) begin
                    state_d = StStoreTo;
                end else if (fall) begin
                    cnt_d   = '0;
                    state_d = StSettle;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StSettle: begin
                route_pwm = 1'b1;
                if (cnt_q == CW'(SETTLE_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = StStore;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StStore, StStoreTo: begin
                dist_valid = 1'b1;
                cnt_d      = '0;
                state_d    = StGap;
            end
            StGap: begin
                if (cnt_q == CW'(GAP_CYCLES - 1)) begin
                    cnt_d = '0;
                    if (idx_q != IW'(N_SENSORS - 1)) begin
                        idx_d   = idx_q + IW'(1);
                        state_d = StClear;
                    end else begin
                        scan_done_d = 1'b1;
                        idx_d       = '0;
                        state_d     = enable ? StClear : StIdle;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign pwm_out       = route_pwm & sel;
    assign dist_out      = dist_q;
    assign dist_idx      = idx_q;
    assign timeout_flags = to_flags_q;
    assign scan_done     = scan_done_q;

endmodule

// File: tb/tb_sensor_scan_ctrl.sv
// Directed bench for sensor_scan_ctrl with short phases (2 sensors, 4-cycle
// trigger, 200-cycle timeout, 2-cycle settle, 10-cycle gap).
module tb_sensor_scan_ctrl;

    localparam int unsigned N  = 2;
    localparam int unsigned DW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [N-1:0]  pwm_in;
    logic [N-1:0]  trig;
    logic          pwm_out;
    logic          meas_reset;
    logic [DW-1:0] meas_distance;
    logic [N*DW-1:0] dist_out;
    logic          dist_valid;
    logic          dist_idx;
    logic [N-1:0]  timeout_flags;
    logic          scan_done;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sensor_scan_ctrl #(
        .N_SENSORS      (N),
        .DW             (DW),
        .TRIG_CYCLES    (4),
        .TIMEOUT_CYCLES (200),
        .SETTLE_CYCLES  (2),
        .GAP_CYCLES     (10)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .pwm_in        (pwm_in),
        .trig          (trig),
        .pwm_out       (pwm_out),
        .meas_reset    (meas_reset),
        .meas_distance (meas_distance),
        .dist_out      (dist_out),
        .dist_valid    (dist_valid),
        .dist_idx      (dist_idx),
        .timeout_flags (timeout_flags),
        .scan_done     (scan_done)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_trig(input int s, input logic lvl);
        int n = 0;
        while (trig[s] !== lvl && n < 2000) begin
            tick();
            n++;
        end
        check($sformatf("trig%0d_reach_%0d", s, lvl), 64'(trig[s]), 64'(lvl));
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (dist_valid !== 1'b1 && n < 2000);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (scan_done !== 1'b1 && n < 2000);
    endtask

    initial begin
        int   n;
        logic seen;
        logic [1:0] exp_trig [7];
        logic       exp_mr   [7];

        reset         = 1'b1;
        enable        = 1'b1;
        pwm_in        = '0;
        meas_distance = '0;
        @(negedge clk);

        // Reset held with enable high: everything quiet.
        seen = 1'b0;
        repeat (10) begin
            tick();
            seen |= (|trig) | meas_reset | pwm_out | dist_valid | scan_done | (|timeout_flags)
                    | (|dist_out);
        end
        check("reset_quiet", 64'(seen), 64'd0);
        check("reset_dist", 64'(dist_out), 64'd0);

        // Release: 2 cycles of meas_reset, then trig=01 for exactly 4 cycles.
        exp_mr   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        exp_trig = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00};
        reset = 1'b0;
        for (int k = 0; k < 7; k++) begin
            tick();
            check($sformatf("startup_mr_%0d", k), 64'(meas_reset), 64'(exp_mr[k]));
            check($sformatf("startup_trig_%0d", k), 64'(trig), 64'(exp_trig[k]));
        end

        // Sensor 0: pulse 20 cycles after trigger end, 20 cycles wide.
        repeat (20) tick();
        pwm_in[0]     = 1'b1;
        meas_distance = 16'd20;
        tick();
        check("s0_sync_not_yet", 64'(pwm_out), 64'd0);
        tick();
        check("s0_pwm_out_high", 64'(pwm_out), 64'd1);
        repeat (18) tick();
        pwm_in[0] = 1'b0;
        // First sampling edge, sync edge, detect edge, then 2 settle cycles.
        wait_valid(n);
        check("s0_store_latency", 64'(n), 64'd5);
        check("s0_idx", 64'(dist_idx), 64'd0);
        tick();
        check("s0_valid_one_cycle", 64'(dist_valid), 64'd0);
        check("s0_dist", 64'(dist_out[15:0]), 64'd20);
        check("s0_flag", 64'(timeout_flags[0]), 64'd0);

        // Sensor 1 stays low: timeout 200 cycles after its trigger ends.
        wait_trig(1, 1'b1);
        wait_trig(1, 1'b0);
        wait_valid(n);
        check("s1_timeout_latency", 64'(n), 64'd200);
        check("s1_idx", 64'(dist_idx), 64'd1);
        tick();
        check("s1_dist_to", 64'(dist_out[31:16]), 64'hFFFF);
        check("s1_flag_to", 64'(timeout_flags[1]), 64'd1);
        check("s0_dist_persist", 64'(dist_out[15:0]), 64'd20);
        wait_done(n);
        check("scan1_done_gap", 64'(n), 64'd10);
        tick();
        check("scan1_done_pulse", 64'(scan_done), 64'd0);

        // Scan 2, sensor 0: glitch on unselected line must not reach pwm_out.
        wait_trig(0, 1'b1);
        wait_trig(0, 1'b0);
        pwm_in[1] = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (k == 3) pwm_in[1] = 1'b0;
            tick();
            seen |= pwm_out;
        end
        check("glitch_pwm_out", 64'(seen), 64'd0);
        repeat (5) tick();
        pwm_in[0]     = 1'b1;
        meas_distance = 16'd33;
        repeat (30) tick();
        pwm_in[0] = 1'b0;
        wait_valid(n);
        check("s0b_store_latency", 64'(n), 64'd5);
        tick();
        check("s0b_dist", 64'(dist_out[15:0]), 64'd33);

        // Sensor 1 stuck high from before its trigger: no edge, so timeout.
        pwm_in[1] = 1'b1;
        wait_trig(1, 1'b1);
        wait_trig(1, 1'b0);
        wait_valid(n);
        check("s1_stuck_latency", 64'(n), 64'd200);
        tick();
        check("s1_stuck_dist", 64'(dist_out[31:16]), 64'hFFFF);
        check("s1_stuck_flag", 64'(timeout_flags[1]), 64'd1);
        wait_done(n);
        check("scan2_done_gap", 64'(n), 64'd10);

        // Scan 3: drop enable during sensor 0's high phase; scan still completes.
        wait_trig(0, 1'b1);
        wait_trig(0, 1'b0);
        repeat (10) tick();
        pwm_in[0]     = 1'b1;
        meas_distance = 16'd77;
        repeat (3) tick();
        enable = 1'b0;
        repeat (20) tick();
        pwm_in[0] = 1'b0;
        wait_valid(n);
        check("s0c_store_latency", 64'(n), 64'd5);
        tick();
        check("s0c_dist", 64'(dist_out[15:0]), 64'd77);

        // Sensor 1 was high on entry; a real low-high-low pulse, sized to fit the
        // 200-cycle timeout window, now stores normally and clears the flag.
        wait_trig(1, 1'b1);
        wait_trig(1, 1'b0);
        repeat (5) tick();
        pwm_in[1] = 1'b0;
        repeat (15) tick();
        pwm_in[1]     = 1'b1;
        meas_distance = 16'd500;
        repeat (150) tick();
        pwm_in[1] = 1'b0;
        wait_valid(n);
        check("s1_pulse_latency", 64'(n), 64'd5);
        check("s1_pulse_idx", 64'(dist_idx), 64'd1);
        tick();
        check("s1_pulse_dist", 64'(dist_out[31:16]), 64'd500);
        check("s1_pulse_flags", 64'(timeout_flags), 64'd0);
        wait_done(n);
        check("scan3_done_gap", 64'(n), 64'd10);

        // Enable low: back to idle, no further activity.
        seen = 1'b0;
        repeat (30) begin
            tick();
            seen |= (|trig) | meas_reset | scan_done | dist_valid;
        end
        check("idle_quiet", 64'(seen), 64'd0);

        // Reset during a trigger aborts immediately and clears results.
        enable = 1'b1;
        wait_trig(0, 1'b1);
        tick();
        reset = 1'b1;
        tick();
        check("rst_trig_drop", 64'(trig), 64'd0);
        check("rst_dist_clear", 64'(dist_out), 64'd0);
        check("rst_flags_clear", 64'(timeout_flags), 64'd0);
        reset  = 1'b0;
        enable = 1'b0;
        tick();
        check("post_rst_trig", 64'(trig), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
